// File: rtl/pool_shaper_pkg.sv
// Shared types, defaults and helpers for the pool shaper.
// Imported by pool_fifo and pool_shaper.
package pool_shaper_pkg;

    localparam int N_IN_DEF      = 40;
    localparam int N_OUT_DEF     = 8;
    localparam int CH_W_DEF      = 4;
    localparam int DW_DEF        = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int BURST_MAX_DEF = 0;
    localparam int GAP_DEF       = 1;

    typedef struct packed {
        logic [CH_W_DEF-1:0] chnum;
        logic [DW_DEF-1:0]   data;
    } pool_word_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pool_fifo.sv
// Per-input synchronous FIFO with synchronous flush.
// Pointers carry one extra wrap bit to tell full from empty.
module pool_fifo
    import pool_shaper_pkg::*;
#(
    parameter int  DEPTH  = DEPTH_DEF,
    parameter type word_t = pool_word_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  word_t wdata,
    output logic  full,
    output logic  empty,
    output word_t rdata
);

    localparam int AW = clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("pool_fifo: DEPTH must be a power of 2 and >= 2");
    end

    word_t       mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr[AW-1:0]];

    // Pointer update; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pool_shaper.sv
// Merges N_IN input pools into N_OUT shaped outputs with
// per-input burst credits and per-output minimum word gap.
module pool_shaper
    import pool_shaper_pkg::*;
#(
    parameter int N_IN      = N_IN_DEF,
    parameter int N_OUT     = N_OUT_DEF,
    parameter int CH_W      = CH_W_DEF,
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int GAP       = GAP_DEF,
    localparam int IDX_W    = clog2(N_IN),
    localparam int OCH_W    = IDX_W + CH_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   chip_head_in,
    input  logic [N_IN-1:0]        pool_vld_in,
    input  logic [N_IN*CH_W-1:0]   pool_chnum_in,
    input  logic [N_IN*DW-1:0]     pool_data_in,
    input  logic [N_IN-1:0]        pool_10ms_timer,
    output logic                   chip_head_out,
    output logic [N_OUT-1:0]       shape_vld_out,
    output logic [N_OUT*OCH_W-1:0] shape_chnum_out,
    output logic [N_OUT*DW-1:0]    shape_data_out,
    output logic [N_IN-1:0]        pool_ovf_out
);

    localparam int G = N_IN / N_OUT;
    localparam int LW = (G > 1) ? clog2(G) : 1;
    localparam bit UNLIM = (BURST_MAX == 0);
    localparam logic [7:0] BMAX = 8'(BURST_MAX);
    localparam logic [7:0] GAP_M1 = (GAP > 1) ? 8'(GAP - 1) : 8'd0;

    if (N_IN % N_OUT != 0) begin : g_bad_ratio
        $error("pool_shaper: N_IN must be a multiple of N_OUT");
    end

    typedef struct packed {
        logic [CH_W-1:0] chnum;
        logic [DW-1:0]   data;
    } word_t;

    word_t            wword  [N_IN];
    word_t            rword  [N_IN];
    logic [7:0]       cred   [N_IN];
    logic [N_IN-1:0]  full;
    logic [N_IN-1:0]  empty;
    logic [N_IN-1:0]  push;
    logic [N_IN-1:0]  pop;
    logic [N_IN-1:0]  elig;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign wword[i] = {pool_chnum_in[i*CH_W +: CH_W],
                           pool_data_in[i*DW +: DW]};
        assign push[i]  = pool_vld_in[i] && !full[i] && !chip_head_in;
        assign elig[i]  = !empty[i] && (UNLIM || cred[i] < BMAX);

        pool_fifo #(
            .DEPTH  (DEPTH),
            .word_t (word_t)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .flush (chip_head_in),
            .wdata (wword[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .rdata (rword[i])
        );
    end

    // Window credits: a tick opens a new window, counting a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) cred[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (chip_head_in)
                    cred[i] <= '0;
                else if (pool_10ms_timer[i])
                    cred[i] <= pop[i] ? 8'd1 : 8'd0;
                else if (pop[i] && cred[i] != 8'hFF)
                    cred[i] <= cred[i] + 8'd1;
            end
        end
    end

    // Sticky overflow: a word arriving at a full FIFO is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pool_ovf_out <= '0;
        else if (chip_head_in)
            pool_ovf_out <= '0;
        else
            pool_ovf_out <= pool_ovf_out | (pool_vld_in & full);
    end

    // Frame-start marker follows the flush by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chip_head_out <= 1'b0;
        else        chip_head_out <= chip_head_in;
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        logic [G-1:0]     el;
        logic [G-1:0]     gnt;
        logic             any;
        logic [LW-1:0]    sel;
        logic [LW-1:0]    rr_nxt;
        logic [LW-1:0]    rr_ptr;
        logic [7:0]       gap_cnt;
        word_t            w_sel;
        logic [IDX_W-1:0] src;
        logic             vld_q;
        logic [OCH_W-1:0] chn_q;
        logic [DW-1:0]    dat_q;

        assign el = elig[o*G +: G];
        assign pop[o*G +: G] = gnt;

        // Round-robin pick from rr_ptr upward while the output is free.
        always_comb begin
            int j;
            j   = 0;
            any = 1'b0;
            sel = '0;
            gnt = '0;
            for (int k = 0; k < G; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= G) j = j - G;
                if (!any && el[j] && gap_cnt == 8'd0 && !chip_head_in) begin
                    any = 1'b1;
                    sel = LW'(j);
                end
            end
            for (int k = 0; k < G; k++) gnt[k] = any && (sel == LW'(k));
            rr_nxt = (sel == LW'(G - 1)) ? '0 : sel + LW'(1);
            w_sel  = rword[o*G + int'(sel)];
            src    = IDX_W'(o*G) + IDX_W'(sel);
        end

        // Arbiter state and registered output word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr  <= '0;
                gap_cnt <= '0;
                vld_q   <= 1'b0;
                chn_q   <= '0;
                dat_q   <= '0;
            end else if (chip_head_in) begin
                rr_ptr  <= '0;
                gap_cnt <= '0;
                vld_q   <= 1'b0;
            end else begin
                vld_q <= any;
                if (any) begin
                    rr_ptr  <= rr_nxt;
                    gap_cnt <= GAP_M1;
                    chn_q   <= {src, w_sel.chnum};
                    dat_q   <= w_sel.data;
                end else if (gap_cnt != 8'd0) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
            end
        end

        assign shape_vld_out[o]               = vld_q;
        assign shape_chnum_out[o*OCH_W +: OCH_W] = chn_q;
        assign shape_data_out[o*DW +: DW]     = dat_q;
    end

endmodule

// File: tb/tb_pool_shaper.sv
// Directed bench: dut_a uses defaults, dut_b uses
// BURST_MAX=2 and GAP=3.
module tb_pool_shaper;

    localparam int NI = 40;
    localparam int NO = 8;
    localparam int CW = 4;
    localparam int DW = 16;
    localparam int OW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI*CW-1:0] chn_in;
    logic [NI*DW-1:0] dat_in;
    logic [NI-1:0]    vld_a, tmr_a, vld_b, tmr_b;
    logic             hd_a, hd_b, hdo_a, hdo_b;
    logic [NO-1:0]    sv_a, sv_b;
    logic [NO*OW-1:0] sc_a, sc_b;
    logic [NO*DW-1:0] sd_a, sd_b;
    logic [NI-1:0]    ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;

    pool_shaper dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .chip_head_in    (hd_a),
        .pool_vld_in     (vld_a),
        .pool_chnum_in   (chn_in),
        .pool_data_in    (dat_in),
        .pool_10ms_timer (tmr_a),
        .chip_head_out   (hdo_a),
        .shape_vld_out   (sv_a),
        .shape_chnum_out (sc_a),
        .shape_data_out  (sd_a),
        .pool_ovf_out    (ovf_a)
    );

    pool_shaper #(
        .BURST_MAX (2),
        .GAP       (3)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .chip_head_in    (hd_b),
        .pool_vld_in     (vld_b),
        .pool_chnum_in   (chn_in),
        .pool_data_in    (dat_in),
        .pool_10ms_timer (tmr_b),
        .chip_head_out   (hdo_b),
        .shape_vld_out   (sv_b),
        .shape_chnum_out (sc_b),
        .shape_data_out  (sd_b),
        .pool_ovf_out    (ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int i, input logic [3:0] c, input logic [15:0] d);
        chn_in[i*CW +: CW] = c;
        dat_in[i*DW +: DW] = d;
    endtask

    initial begin
        logic exp_v;
        rst_n  = 1'b0;
        chn_in = '0;
        dat_in = '0;
        vld_a  = '0;
        tmr_a  = '0;
        vld_b  = '0;
        tmr_b  = '0;
        hd_a   = 1'b0;
        hd_b   = 1'b0;
        step(2);
        chk("rst_a", 64'({hdo_a, |sv_a, |sc_a, |sd_a, |ovf_a}), 64'd0);
        chk("rst_b", 64'({hdo_b, |sv_b, |sc_b, |sd_b, |ovf_b}), 64'd0);
        rst_n = 1'b1;
        step(1);

        // single word: input 7 -> output 1 two cycles later
        wr(7, 4'h3, 16'hBEEF);
        vld_a[7] = 1'b1;
        step(1);
        vld_a = '0;
        chk("single_early", 64'(sv_a), 64'd0);
        step(1);
        chk("single_vld", 64'(sv_a), 64'h02);
        chk("single_chn", 64'(sc_a[1*OW +: OW]), 64'h073);
        chk("single_dat", 64'(sd_a[1*DW +: DW]), 64'hBEEF);
        step(1);
        chk("single_off", 64'(sv_a[1]), 64'd0);
        chk("single_hold", 64'(sc_a[1*OW +: OW]), 64'h073);

        // round robin over inputs 0..4 of output 0
        for (int i = 0; i < 5; i++) begin
            wr(i, 4'(i), 16'(16'h100 + i));
            vld_a[i] = 1'b1;
        end
        step(1);
        vld_a = '0;
        chk("rr_early", 64'(sv_a[0]), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("rr_vld", 64'(sv_a[0]), 64'd1);
            chk("rr_chn", 64'(sc_a[0 +: OW]), 64'((k << 4) | k));
            chk("rr_dat", 64'(sd_a[0 +: DW]), 64'(16'h100 + k));
        end
        step(1);
        chk("rr_idle", 64'(sv_a[0]), 64'd0);
        wr(2, 4'hA, 16'h0200);
        wr(0, 4'hB, 16'h0300);
        vld_a[0] = 1'b1;
        vld_a[2] = 1'b1;
        step(1);
        vld_a = '0;
        step(1);
        chk("rr_wrap0", 64'(sc_a[0 +: OW]), 64'h00B);
        chk("rr_wrap0_d", 64'(sd_a[0 +: DW]), 64'h0300);
        step(1);
        chk("rr_wrap2", 64'(sc_a[0 +: OW]), 64'h02A);
        chk("rr_wrap2_v", 64'(sv_a[0]), 64'd1);

        // flush with three words queued
        for (int i = 0; i < 3; i++) begin
            wr(i, 4'h1, 16'hDEAD);
            vld_a[i] = 1'b1;
        end
        step(1);
        vld_a = '0;
        hd_a  = 1'b1;
        step(1);
        hd_a = 1'b0;
        chk("flush_vld", 64'(sv_a), 64'd0);
        chk("flush_hdo", 64'(hdo_a), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("flush_stale", 64'(sv_a), 64'd0);
        end
        chk("flush_hdo_off", 64'(hdo_a), 64'd0);

        // gap 3 on dut_b: grants at P1, P4, P7
        for (int i = 0; i < 3; i++) begin
            wr(i, 4'h2, 16'(16'h10 + i));
            vld_b[i] = 1'b1;
        end
        for (int c = 0; c < 9; c++) begin
            step(1);
            vld_b = '0;
            exp_v = (c == 1 || c == 4 || c == 7);
            chk("gap_vld", 64'(sv_b[0]), 64'(exp_v));
            if (exp_v)
                chk("gap_dat", 64'(sd_b[0 +: DW]), 64'(16'h10 + (c - 1) / 3));
        end

        // burst limit 2 on input 5 (output 1)
        for (int c = 0; c < 12; c++) begin
            vld_b = '0;
            if (c < 4) begin
                wr(5, 4'h5, 16'(16'h50 + c));
                vld_b[5] = 1'b1;
            end
            step(1);
            exp_v = (c == 1 || c == 4);
            chk("burst_vld", 64'(sv_b[1]), 64'(exp_v));
            if (c == 4)
                chk("burst_dat", 64'(sd_b[1*DW +: DW]), 64'h51);
        end
        vld_b = '0;
        tmr_b[5] = 1'b1;
        step(1);
        tmr_b = '0;
        chk("tick_same", 64'(sv_b[1]), 64'd0);
        step(1);
        chk("tick_vld", 64'(sv_b[1]), 64'd1);
        chk("tick_dat", 64'(sd_b[1*DW +: DW]), 64'h52);
        chk("tick_chn", 64'(sc_b[1*OW +: OW]), 64'h055);
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("tick_gap", 64'(sv_b[1]), 64'(c == 2));
        end
        chk("tick_dat2", 64'(sd_b[1*DW +: DW]), 64'h53);

        // overflow on input 10 once its credit is exhausted
        for (int c = 0; c < 7; c++) begin
            vld_b = '0;
            if (c < 2) begin
                wr(10, 4'hA, 16'(16'hA0 + c));
                vld_b[10] = 1'b1;
            end
            step(1);
            chk("ovf_pre", 64'(sv_b[2]), 64'(c == 1 || c == 4));
        end
        for (int k = 0; k < 6; k++) begin
            wr(10, 4'hA, 16'(16'hB0 + k));
            vld_b[10] = 1'b1;
            step(1);
            chk("ovf_bit", 64'(ovf_b[10]), 64'(k >= 4));
            chk("ovf_stall", 64'(sv_b[2]), 64'd0);
        end
        vld_b = '0;
        step(2);
        chk("ovf_sticky", 64'(ovf_b), 64'h400);
        hd_b = 1'b1;
        step(1);
        hd_b = 1'b0;
        chk("ovf_clear", 64'(ovf_b), 64'd0);
        chk("ovf_hdo", 64'(hdo_b), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("ovf_flushed", 64'(sv_b), 64'd0);
        end

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            wr(i, 4'h7, 16'h7777);
            vld_a[i] = 1'b1;
        end
        step(1);
        vld_a = '0;
        step(1);
        chk("arst_pre", 64'(sv_a[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(sv_a), 64'd0);
        chk("arst_out", 64'({|sc_a, |sd_a, hdo_a}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("arst_empty", 64'(sv_a), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
